// File: rtl/sram_1rw_ctrl_if.sv
// Request/response bundle for sram_1rw_ctrl: valid/ready request channel,
// unthrottled read response channel and init status.
interface sram_1rw_ctrl_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    localparam int MASK_W = DATA_W / 8;

    logic              REQ_VALID;
    logic              REQ_READY;
    logic              REQ_WE;
    logic [ADDR_W-1:0] A;
    logic [DATA_W-1:0] I;
    logic [MASK_W-1:0] WMASK;
    logic              RSP_VALID;
    logic [DATA_W-1:0] O;
    logic              INIT_DONE;

    // Requester side (cache / scratchpad control logic)
    modport master (
        output REQ_VALID, REQ_WE, A, I, WMASK,
        input  REQ_READY, RSP_VALID, O, INIT_DONE
    );

    // Storage side
    modport slave (
        input  REQ_VALID, REQ_WE, A, I, WMASK,
        output REQ_READY, RSP_VALID, O, INIT_DONE
    );
endinterface

// File: rtl/sram_1rw_ctrl.sv
// Single-port SRAM model with valid/ready front end, byte-lane write mask,
// optional output register and a post-reset sweep that writes INIT_VAL everywhere.
module sram_1rw_ctrl #(
    parameter int                ADDR_W   = 6,
    parameter int                DEPTH    = 64,
    parameter int                DATA_W   = 32,
    parameter int                OUT_REG  = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic          CE,
    input  logic          RST,
    sram_1rw_ctrl_if.slave bus
);

    localparam int MASK_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] init_cnt_reg;
    logic [ADDR_W-1:0] init_cnt_next;
    logic              init_we;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              in_range;
    logic              acc_wr;
    logic              acc_rd;

    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [MASK_W-1:0] lane_we;

    logic              rq_valid_reg;
    logic              rq_hit_reg;
    logic [ADDR_W-1:0] rq_addr_reg;
    logic              rd_valid_reg;
    logic [DATA_W-1:0] rd_data_reg;

    // ------------------------------------------------------------------
    // Init / run state machine
    // ------------------------------------------------------------------
    always_ff @(posedge CE) begin
        if (RST) begin
            state_reg    <= ST_INIT;
            init_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            init_cnt_reg <= init_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        init_cnt_next = init_cnt_reg;
        init_we       = 1'b0;
        case (state_reg)
            ST_INIT: begin
                init_we = 1'b1;
                if (init_cnt_reg == LAST_ADDR) begin
                    state_next    = ST_RUN;
                    init_cnt_next = '0;
                end else begin
                    init_cnt_next = init_cnt_reg + 1'b1;
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next    = ST_INIT;
                init_cnt_next = '0;
            end
        endcase
    end

    assign bus.REQ_READY = (state_reg == ST_RUN);
    assign bus.INIT_DONE = (state_reg == ST_RUN);

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign accept   = bus.REQ_VALID & bus.REQ_READY;
    assign in_range = ({1'b0, bus.A} < DEPTH_EXT);
    assign acc_wr   = accept & bus.REQ_WE & in_range;
    assign acc_rd   = accept & ~bus.REQ_WE;

    // The single write port is shared between the init sweep and user writes;
    // the two never coincide because requests are only accepted in RUN.
    always_comb begin
        if (init_we) begin
            wr_addr = init_cnt_reg;
            wr_data = INIT_VAL;
        end else begin
            wr_addr = bus.A;
            wr_data = bus.I;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < MASK_W; gi++) begin : g_lane_we
            assign lane_we[gi] = ~RST & (init_we | (acc_wr & bus.WMASK[gi]));
        end
    endgenerate

    always_ff @(posedge CE) begin
        for (int b = 0; b < MASK_W; b++) begin
            if (lane_we[b]) begin
                mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline: request capture, then registered array read.
    // The array is read one edge after accept, so a write accepted on the
    // previous edge is already visible.
    // ------------------------------------------------------------------
    always_ff @(posedge CE) begin
        if (RST) begin
            rq_valid_reg <= 1'b0;
            rq_hit_reg   <= 1'b0;
            rq_addr_reg  <= '0;
        end else begin
            rq_valid_reg <= acc_rd;
            if (acc_rd) begin
                rq_hit_reg  <= in_range;
                rq_addr_reg <= bus.A;
            end
        end
    end

    always_ff @(posedge CE) begin
        if (RST) begin
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            rd_valid_reg <= rq_valid_reg;
            if (rq_valid_reg) begin
                rd_data_reg <= rq_hit_reg ? mem[rq_addr_reg] : '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional output register; data holds between responses either way.
    // ------------------------------------------------------------------
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              out_valid_reg;
            logic [DATA_W-1:0] out_data_reg;

            always_ff @(posedge CE) begin
                if (RST) begin
                    out_valid_reg <= 1'b0;
                    out_data_reg  <= '0;
                end else begin
                    out_valid_reg <= rd_valid_reg;
                    if (rd_valid_reg) begin
                        out_data_reg <= rd_data_reg;
                    end
                end
            end

            assign bus.RSP_VALID = out_valid_reg;
            assign bus.O         = out_data_reg;
        end else begin : g_out_direct
            assign bus.RSP_VALID = rd_valid_reg;
            assign bus.O         = rd_data_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sram_1rw_ctrl.sv
// Drives one request stream into three differently-configured controllers and
// checks every response against a per-instance array model through a scoreboard.
module tb_sram_1rw_ctrl;

    localparam int NDUT = 3;
    localparam int DEPTH_P [NDUT] = '{64, 64, 48};
    localparam int OUT_P   [NDUT] = '{0, 1, 0};
    localparam logic [31:0] INIT_P [NDUT] = '{32'h0000_0000, 32'hA5A5_0F0F, 32'h1234_5678};

    typedef struct {
        int          dut;
        logic [31:0] data;
        int          due;
        int          ep;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [5:0]  req_a = '0;
    logic [31:0] req_d = '0;
    logic [3:0]  req_m = '0;
    logic        stim_done = 1'b0;

    logic [NDUT-1:0] rdy_w;
    logic [NDUT-1:0] done_w;
    logic [NDUT-1:0] rsp_valid_w;
    logic [31:0]     o_w [NDUT];

    // Reference model state (owned by the posedge process)
    logic [31:0] mdl [NDUT][64];
    int          init_left [NDUT];
    int          edge_n = 0;
    int          epoch  = 0;
    exp_t        sb_q[$];

    // Checker state (owned by the negedge process)
    int          rd_ptr [NDUT];
    int          seen_ep [NDUT];
    logic [31:0] last_o [NDUT];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NDUT; gi++) begin : g_dut
            sram_1rw_ctrl_if #(.ADDR_W(6), .DATA_W(32)) bus ();

            assign bus.REQ_VALID = req_valid;
            assign bus.REQ_WE    = req_we;
            assign bus.A         = req_a;
            assign bus.I         = req_d;
            assign bus.WMASK     = req_m;

            sram_1rw_ctrl #(
                .ADDR_W  (6),
                .DEPTH   (DEPTH_P[gi]),
                .DATA_W  (32),
                .OUT_REG (OUT_P[gi]),
                .INIT_VAL(INIT_P[gi])
            ) u_dut (
                .CE (clk),
                .RST(rst),
                .bus(bus)
            );

            assign rdy_w[gi]       = bus.REQ_READY;
            assign done_w[gi]      = bus.INIT_DONE;
            assign rsp_valid_w[gi] = bus.RSP_VALID;
            assign o_w[gi]         = bus.O;
        end
    endgenerate

    // Behavioural model: sweep length, masked writes, read result at accept time
    always @(posedge clk) begin
        exp_t e;
        edge_n++;
        if (rst) begin
            epoch++;
            for (int d = 0; d < NDUT; d++) init_left[d] = DEPTH_P[d];
        end else begin
            for (int d = 0; d < NDUT; d++) begin
                if (init_left[d] > 0) begin
                    mdl[d][DEPTH_P[d] - init_left[d]] = INIT_P[d];
                    init_left[d]--;
                end else if (req_valid) begin
                    if (req_we) begin
                        if (int'(req_a) < DEPTH_P[d]) begin
                            for (int b = 0; b < 4; b++)
                                if (req_m[b]) mdl[d][req_a][8*b +: 8] = req_d[8*b +: 8];
                        end
                    end else begin
                        e.dut  = d;
                        e.data = (int'(req_a) < DEPTH_P[d]) ? mdl[d][req_a] : 32'h0;
                        e.due  = edge_n + 1 + OUT_P[d];
                        e.ep   = epoch;
                        sb_q.push_back(e);
                    end
                end
            end
        end
    end

    function automatic int next_idx(input int d, input int from);
        int k;
        k = from;
        while (k < sb_q.size() && (sb_q[k].dut != d || sb_q[k].ep != epoch)) k++;
        return k;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        logic run_exp;
        if (edge_n >= 1) begin
            for (int d = 0; d < NDUT; d++) begin
                if (seen_ep[d] != epoch) begin
                    seen_ep[d] = epoch;
                    last_o[d]  = 32'h0;
                end
                rd_ptr[d] = next_idx(d, rd_ptr[d]);
                run_exp   = (init_left[d] == 0);

                n_tests++;
                if (rdy_w[d] !== run_exp || done_w[d] !== run_exp) begin
                    n_fail++;
                    $display("FAIL dut%0d ready/init_done edge %0d: got %b/%b expected %b",
                             d, edge_n, rdy_w[d], done_w[d], run_exp);
                end

                if (rsp_valid_w[d] !== 1'b0) begin
                    n_tests++;
                    if (rd_ptr[d] >= sb_q.size()) begin
                        n_fail++;
                        $display("FAIL dut%0d unexpected rsp edge %0d: got valid=%b O=%h expected no response",
                                 d, edge_n, rsp_valid_w[d], o_w[d]);
                    end else begin
                        e = sb_q[rd_ptr[d]];
                        rd_ptr[d]++;
                        if (o_w[d] !== e.data || edge_n != e.due) begin
                            n_fail++;
                            $display("FAIL dut%0d rsp edge %0d: got O=%h expected O=%h at edge %0d",
                                     d, edge_n, o_w[d], e.data, e.due);
                        end else begin
                            $display("[TB] dut%0d read rsp edge %0d O=%h ok", d, edge_n, o_w[d]);
                        end
                        last_o[d] = e.data;
                    end
                end else begin
                    n_tests++;
                    if (o_w[d] !== last_o[d]) begin
                        n_fail++;
                        $display("FAIL dut%0d O hold edge %0d: got %h expected %h",
                                 d, edge_n, o_w[d], last_o[d]);
                    end
                    if (rd_ptr[d] < sb_q.size() && sb_q[rd_ptr[d]].due <= edge_n) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL dut%0d missing rsp edge %0d: got no response expected O=%h",
                                 d, edge_n, sb_q[rd_ptr[d]].data);
                        rd_ptr[d]++;
                    end
                end
            end
        end
        if (stim_done) begin
            for (int d = 0; d < NDUT; d++) begin
                rd_ptr[d] = next_idx(d, rd_ptr[d]);
                n_tests++;
                if (rd_ptr[d] < sb_q.size()) begin
                    n_fail++;
                    $display("FAIL dut%0d outstanding reads at end: got %0d pending expected 0",
                             d, sb_q.size() - rd_ptr[d]);
                end
            end
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic idle();
        req_valid = 1'b0;
        req_we    = 1'($urandom_range(0, 1));
        req_a     = 6'($urandom_range(0, 63));
        req_d     = $urandom;
        req_m     = 4'($urandom_range(0, 15));
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [5:0] a, input logic [31:0] d,
                         input logic [3:0] m);
        req_valid = 1'b1;
        req_we    = we;
        req_a     = a;
        req_d     = d;
        req_m     = m;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_run();
        for (int k = 0; k < 200; k++) begin
            if (&done_w) break;
            idle();
        end
    endtask

    task automatic read_all();
        for (int a = 0; a < 64; a++) issue(1'b0, 6'(a), 32'h0, 4'h0);
    endtask

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            init_left[d] = DEPTH_P[d];
            rd_ptr[d]    = 0;
            seen_ep[d]   = 0;
            last_o[d]    = 32'h0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        wait_run();
        read_all();
        repeat (3) idle();

        issue(1'b1, 6'd5, 32'hDEAD_BEEF, 4'hF);
        issue(1'b0, 6'd5, 32'h0, 4'h0);
        repeat (3) idle();

        issue(1'b1, 6'd5, 32'h1122_3344, 4'h5);
        issue(1'b0, 6'd5, 32'h0, 4'h0);
        issue(1'b1, 6'd5, 32'hFFFF_FFFF, 4'h0);
        issue(1'b0, 6'd5, 32'h0, 4'h0);
        repeat (3) idle();

        for (int a = 0; a < 8; a++) issue(1'b0, 6'(a), 32'h0, 4'h0);
        repeat (4) idle();

        issue(1'b1, 6'd50, 32'hCAFE_F00D, 4'hF);
        issue(1'b0, 6'd50, 32'h0, 4'h0);
        repeat (3) idle();

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) != 0)
                issue(1'($urandom_range(0, 1)),
                      ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63)),
                      $urandom, 4'($urandom_range(0, 15)));
            else
                idle();
        end
        repeat (3) idle();

        // Reset lands on the edge where the read response would have been produced
        issue(1'b0, 6'd3, 32'h0, 4'h0);
        rst = 1'b1;
        issue(1'b1, 6'd3, 32'h5555_AAAA, 4'hF);
        rst = 1'b0;
        wait_run();
        read_all();
        repeat (4) idle();

        stim_done = 1'b1;
        repeat (5) @(posedge clk);
        $display("FAIL watchdog: got no summary expected summary after stimulus end");
        $fatal(1);
    end

endmodule
